salsa_20_8_ctrl: RTL and testbench
==================================

// Module: salsa_20_8_ctrl
// PURPOSE
//  Control and feed-forward end of the Salsa20/8 datapath (salsa_20_8_dp) used by the scrypt BlockMix.
//  - Accepts a 512-bit block through a valid/ready handshake and sequences the datapath through
//    NUM_DROUNDS double rounds by driving its sel_in / write_temp / valid controls.
//  - Adds the datapath result word-wise to the original block (feed-forward).
//  - Presents the 512-bit Salsa20/8 output through a valid/ready handshake.
// PARAMETERS
//  NUM_DROUNDS  4   double rounds per block; 4 gives Salsa20/8. Legal range >= 1.
// PORTS
//  clk           in   1    clock
//  reset_n       in   1    asynchronous, active-low reset
//  in_valid      in   1    input block valid
//  in_ready      out  1    controller can accept a block
//  din           in   512  input block; word i = din[32i+31:32i]
//  out_valid     out  1    dout holds a finished block
//  out_ready     in   1    consumer accepts dout
//  dout          out  512  Salsa20/8(din) = din + core(din), word i at [32i+31:32i]
//  busy          out  1    block in flight (state != IDLE)
//  dp_x          out  512  to datapath x0..x15 (word i -> x_i)
//  dp_sel_in     out  1    to datapath sel_in: 0 = load dp_x, 1 = iterate temp regs
//  dp_write_temp out  1    to datapath write_temp
//  dp_valid      out  1    to datapath valid (enables its outputs)
//  dp_out        in   512  from datapath out0..out15 (word i <- out_i)
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, rcnt=0, orig=0, dout=0.
//    Outputs during/after reset: out_valid=0, busy=0, in_ready=1, dp_sel_in=0, dp_write_temp=0, dp_valid=0.
//  - FSM states: IDLE -> ROUND -> ADD -> OUT -> IDLE.
//  - IDLE:
//      in_ready=1.
//      On in_valid&in_ready: orig<=din, rcnt<=0, go to ROUND.
//  - ROUND:
//      dp_write_temp=1; dp_sel_in=(rcnt!=0).
//      rcnt<=rcnt+1. When rcnt==NUM_DROUNDS-1, go to ADD.
//      Lasts exactly NUM_DROUNDS cycles.
//  - ADD (1 cycle):
//      dp_valid=1, dp_write_temp=0.
//      dout[i] <= orig[i] + dp_out[i], each word mod 2^32 (carry discarded, no carry between words).
//      Go to OUT.
//  - OUT:
//      out_valid=1; dout and orig held stable.
//      On out_ready: go to IDLE.
//  - dp_x = orig at all times (registered, stable during ROUND).
//  - dp_valid=0 and dp_write_temp=0 in IDLE and OUT.
//  - in_ready=0 in every state except IDLE. No overlap: the next block is accepted only in IDLE,
//    so a block accepted on the out_ready cycle is impossible (earliest accept is 1 cycle later).
//  - in_valid while not IDLE: ignored, din not sampled.
//  - Latency: accept at edge E -> out_valid high after edge E+NUM_DROUNDS+1 (E+5 for default).
//  - rcnt width = max(1, $clog2(NUM_DROUNDS)); NUM_DROUNDS=1 gives a single ROUND cycle with dp_sel_in=0.
//  - Reset mid-operation: immediate return to reset values; the in-flight block is discarded and
//    no out_valid is produced for it.
//  - dout is only updated in ADD; stale dout when out_valid=0 is don't-care.
// TESTING
//  1. Zero block in, with a real salsa_20_8_dp attached -> dout all zero; out_valid after 5 edges past accept.
//  2. RFC 7914 sec.8 Salsa20/8 vector, real salsa_20_8_dp -> dout equals RFC output words 0..15 exactly.
//  3. Stub datapath returning 0xFFFFFFFF per word; din words 0x00000002 -> every dout word 0x00000001
//     (mod-2^32 wrap, no cross-word carry).
//  4. Hold out_ready=0 for 10 cycles after out_valid -> dout stable, in_ready=0, in_valid pulses ignored;
//     out_ready=1 -> IDLE next cycle, in_ready=1.
//  5. Assert reset_n=0 in the 2nd ROUND cycle -> all outputs at reset values immediately, no out_valid;
//     a new block then completes correctly.
//  6. NUM_DROUNDS=1 build -> dp_sel_in stays 0, dp_write_temp high for exactly 1 cycle,
//     out_valid 2 edges after accept.

Source files
------------

// File: rtl/salsa_20_8_ctrl.sv
// Salsa20/8 controller: sequences the double-round datapath, then adds its result
// word-wise onto the original block and hands the sum out through valid/ready.
module salsa_20_8_ctrl #(
  parameter int NUM_DROUNDS = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] dout,
  output logic         busy,
  output logic [511:0] dp_x,
  output logic         dp_sel_in,
  output logic         dp_write_temp,
  output logic         dp_valid,
  input  logic [511:0] dp_out
);

  localparam int RW = (NUM_DROUNDS > 1) ? $clog2(NUM_DROUNDS) : 1;
  localparam logic [RW-1:0] LAST_RND = RW'(NUM_DROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    ADD   = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [RW-1:0]   rcnt_r;
  logic [511:0]    orig_r;
  logic [511:0]    dout_r;
  logic            accept_s;

  // Feed-forward sum: independent 32-bit adds, carries never cross word boundaries.
  function automatic logic [511:0] add_words(input logic [511:0] a, input logic [511:0] b);
    logic [511:0] s;
    s = 512'd0;
    for (int i = 0; i < 16; i++) begin
      s[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
    end
    return s;
  endfunction

  assign accept_s = in_valid && (state_r == IDLE);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Round counter, captured block and result register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt_r <= {RW{1'b0}};
      orig_r <= 512'd0;
      dout_r <= 512'd0;
    end else begin
      if (accept_s) begin
        orig_r <= din;
        rcnt_r <= {RW{1'b0}};
      end else if (state_r == ROUND) begin
        rcnt_r <= rcnt_r + {{(RW-1){1'b0}}, 1'b1};
      end
      if (state_r == ADD) begin
        dout_r <= add_words(orig_r, dp_out);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = ROUND;
        else          state_s = IDLE;
      end
      ROUND: begin
        if (rcnt_r == LAST_RND) state_s = ADD;
        else                    state_s = ROUND;
      end
      ADD: state_s = OUT;
      OUT: begin
        if (out_ready) state_s = IDLE;
        else           state_s = OUT;
      end
      default: state_s = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register
  always_comb begin
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    dp_sel_in     = 1'b0;
    dp_write_temp = 1'b0;
    dp_valid      = 1'b0;
    case (state_r)
      IDLE:  in_ready = 1'b1;
      ROUND: begin
        dp_write_temp = 1'b1;
        // First round loads dp_x into the datapath; later rounds iterate its temp registers.
        dp_sel_in     = (rcnt_r != {RW{1'b0}});
      end
      ADD:   dp_valid  = 1'b1;
      OUT:   out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign busy = (state_r != IDLE);
  assign dp_x = orig_r;
  assign dout = dout_r;

endmodule

// File: tb/tb_salsa_20_8_ctrl.sv
// Directed bench for salsa_20_8_ctrl: a behavioural Salsa20 double-round datapath
// (or a constant stub) sits behind the default build; a second build runs NUM_DROUNDS=1.
module tb_salsa_20_8_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic         dp_sel_in, dp_write_temp, dp_valid;
  logic [511:0] din, dout, dp_x, dp_out;
  logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic         dp_sel_in1, dp_write_temp1, dp_valid1;
  logic [511:0] din1, dout1, dp_x1, dp_out1;

  logic         stub_mode;
  logic [511:0] dp_temp;
  logic [511:0] rfc_in, rfc_out, exp1;
  int           n_vec = 0;
  int           n_err = 0;
  int           lat, wt;
  logic [4:0]   sel_hist;
  logic         seen;

  always #5 clk = ~clk;

  salsa_20_8_ctrl u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .busy(busy), .dp_x(dp_x),
    .dp_sel_in(dp_sel_in), .dp_write_temp(dp_write_temp), .dp_valid(dp_valid), .dp_out(dp_out)
  );

  salsa_20_8_ctrl #(.NUM_DROUNDS(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1), .din(din1),
    .out_valid(out_valid1), .out_ready(out_ready1), .dout(dout1), .busy(busy1), .dp_x(dp_x1),
    .dp_sel_in(dp_sel_in1), .dp_write_temp(dp_write_temp1), .dp_valid(dp_valid1), .dp_out(dp_out1)
  );

  function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  // One Salsa20 double round: four column quarter-rounds, then four row quarter-rounds.
  function automatic logic [511:0] dround(input logic [511:0] xin);
    logic [31:0] x[16];
    int qi[8][4];
    int a, b, c, d;
    logic [511:0] r;
    qi = '{'{0,4,8,12}, '{5,9,13,1}, '{10,14,2,6}, '{15,3,7,11},
           '{0,1,2,3},  '{5,6,7,4},  '{10,11,8,9}, '{15,12,13,14}};
    for (int i = 0; i < 16; i++) x[i] = xin[32*i +: 32];
    for (int k = 0; k < 8; k++) begin
      a = qi[k][0]; b = qi[k][1]; c = qi[k][2]; d = qi[k][3];
      x[b] = x[b] ^ rotl(x[a] + x[d], 7);
      x[c] = x[c] ^ rotl(x[b] + x[a], 9);
      x[d] = x[d] ^ rotl(x[c] + x[b], 13);
      x[a] = x[a] ^ rotl(x[d] + x[c], 18);
    end
    r = 512'd0;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i];
    return r;
  endfunction

  always @(posedge clk) begin
    if (dp_write_temp) dp_temp <= dround(dp_sel_in ? dp_temp : dp_x);
  end

  assign dp_out = stub_mode ? {16{32'hFFFF_FFFF}} : (dp_valid ? dp_temp : 512'd0);

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one block and wait (bounded) for out_valid, logging round controls per cycle.
  task automatic run_block(input logic [511:0] blk);
    din = blk;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0; wt = 0; sel_hist = 5'd0;
    while (!out_valid && lat < 20) begin
      if (dp_write_temp) wt++;
      sel_hist = {sel_hist[3:0], dp_sel_in};
      step();
      lat++;
    end
  endtask

  task automatic release_block(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check(tag, {509'd0, out_valid, busy, in_ready}, {509'd0, 3'b001});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {506'd0, out_valid, busy, in_ready, dp_sel_in, dp_write_temp, dp_valid},
          {506'd0, 6'b001000});
    check({tag, "_dpx"}, dp_x, 512'd0);
    check({tag, "_dout"}, dout, 512'd0);
  endtask

  initial begin
    logic [31:0] wi[16];
    logic [31:0] wo[16];
    wi = '{32'h219a877e, 32'h86c93e4f, 32'he640a97c, 32'h268f7141,
           32'h5b55eeba, 32'hb5c1618c, 32'h1146f80d, 32'h1d3bcd6d,
           32'h19f324ee, 32'h853d9bdf, 32'h4b1e1214, 32'h32aac55a,
           32'h291d0276, 32'h2948c709, 32'h8dc6ebed, 32'h5ec2b8b8};
    wo = '{32'h9c851fa4, 32'h99cc0866, 32'hcbca813b, 32'h05ef0c02,
           32'h81214b04, 32'h7d33fda2, 32'h631c7bfd, 32'h292f6896,
           32'h683139b4, 32'hbce6c9e3, 32'hb7c56bfe, 32'hba966da0,
           32'h10cc24e4, 32'h5c74912c, 32'h3d67ad24, 32'h818f61c7};
    for (int i = 0; i < 16; i++) begin
      rfc_in[32*i +: 32]  = wi[i];
      rfc_out[32*i +: 32] = wo[i];
      din1[32*i +: 32]    = 32'h8000_0000 + 32'(2 * i);
      dp_out1[32*i +: 32] = 32'h8000_0000 + 32'(i);
      exp1[32*i +: 32]    = 32'(3 * i);
    end

    reset_n = 1'b0; in_valid = 1'b0; din = 512'd0; out_ready = 1'b0; stub_mode = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    step(); step();
    check_reset_outputs("rst");
    check("rst1_ctl", {509'd0, out_valid1, busy1, in_ready1}, {509'd0, 3'b001});
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Zero block: Salsa20/8(0) = 0
    run_block(512'd0);
    check("zero_lat", 512'(lat), 512'd5);
    check("zero_wt", 512'(wt), 512'd4);
    check("zero_sel", {507'd0, sel_hist}, {507'd0, 5'b01110});
    check("zero_dout", dout, 512'd0);
    release_block("zero_rel");

    // Published Salsa20/8 test vector
    run_block(rfc_in);
    check("rfc_lat", 512'(lat), 512'd5);
    check("rfc_dpx", dp_x, rfc_in);
    check("rfc_dout", dout, rfc_out);
    release_block("rfc_rel");

    // Constant-stub datapath: 2 + 0xFFFFFFFF wraps to 1 in every word
    stub_mode = 1'b1;
    run_block({16{32'h0000_0002}});
    check("wrap_dout", dout, {16{32'h0000_0001}});
    stub_mode = 1'b0;
    release_block("wrap_rel");

    // Back-pressure: output held, new requests ignored
    run_block(rfc_in);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      din = ~rfc_in;
      step();
      check("hold_ctl", {509'd0, out_valid, in_ready, busy}, {509'd0, 3'b101});
    end
    in_valid = 1'b0;
    check("hold_dout", dout, rfc_out);
    check("hold_dpx", dp_x, rfc_in);
    release_block("hold_rel");

    // Reset during the second round cycle
    din = rfc_in;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | out_valid;
    end
    check("mid_noout", {510'd0, seen, in_ready}, {510'd0, 2'b01});
    run_block(rfc_in);
    check("mid_lat", 512'(lat), 512'd5);
    check("mid_dout", dout, rfc_out);
    release_block("mid_rel");

    // Single double-round build
    in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    lat = 0; wt = 0; seen = 1'b0;
    while (!out_valid1 && lat < 20) begin
      if (dp_write_temp1) wt++;
      seen = seen | dp_sel_in1;
      step();
      lat++;
    end
    check("n1_lat", 512'(lat), 512'd2);
    check("n1_wt", 512'(wt), 512'd1);
    check("n1_sel", {511'd0, seen}, 512'd0);
    check("n1_dout", dout1, exp1);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    check("n1_rel", {509'd0, out_valid1, busy1, in_ready1}, {509'd0, 3'b001});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
